// File: rtl/slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// slave_port_arbiter
//   Shares one slave port among MASTERS requesters. It grants in round-robin
//   order and keeps one transaction outstanding at a time. A watchdog aborts a
//   slave that does not answer and reports it with an error pulse.
//
// Ports
//   clk_i, rst_i      clock (rising edge) and synchronous active-high reset
//   m_req_i           per-requester request, held until m_ack_o/m_err_o
//   m_cmd_i           per-requester command, 0=read 1=write
//   m_addr_i          packed per-requester address, slice i = requester i
//   m_wdata_i         packed per-requester write data, slice i = requester i
//   m_ack_o           1-cycle pulse: the slave accepted the request
//   m_resp_o          1-cycle pulse: m_rdata_o is valid
//   m_err_o           1-cycle pulse: the watchdog aborted the transaction
//   m_rdata_o         read data, shared by all requesters, holds its value
//   s_req_o           1-cycle request pulse to the slave
//   s_cmd_o, s_addr_o command and address of the granted request
//   s_wdata_o         write data of the last granted write
//   s_ack_i, s_resp_i accept and read-response pulses from the slave
//   s_rdata_i         slave read data, valid with s_resp_i
// ---------------------------------------------------------------------------
module slave_port_arbiter #(
   parameter int MASTERS = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [MASTERS-1:0]    m_req_i,
   input  logic [MASTERS-1:0]    m_cmd_i,
   input  logic [MASTERS*AW-1:0] m_addr_i,
   input  logic [MASTERS*DW-1:0] m_wdata_i,
   output logic [MASTERS-1:0]    m_ack_o,
   output logic [MASTERS-1:0]    m_resp_o,
   output logic [MASTERS-1:0]    m_err_o,
   output logic [DW-1:0]         m_rdata_o,
   output logic                  s_req_o,
   output logic                  s_cmd_o,
   output logic [AW-1:0]         s_addr_o,
   output logic [DW-1:0]         s_wdata_o,
   input  logic                  s_ack_i,
   input  logic                  s_resp_i,
   input  logic [DW-1:0]         s_rdata_i
);

   localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   // The timer only has to count up to TIMEOUT-1.
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP} state_e;

   state_e                 state_q, state_d;
   logic [GW-1:0]          rr_q, rr_d;
   logic [GW-1:0]          g_q, g_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [MASTERS-1:0]     m_ack_q, m_ack_d;
   logic [MASTERS-1:0]     m_resp_q, m_resp_d;
   logic [MASTERS-1:0]     m_err_q, m_err_d;
   logic [DW-1:0]          m_rdata_q, m_rdata_d;
   logic                   s_req_q, s_req_d;
   logic                   s_cmd_q, s_cmd_d;
   logic [AW-1:0]          s_addr_q, s_addr_d;
   logic [DW-1:0]          s_wdata_q, s_wdata_d;

   logic [MASTERS-1:0][AW-1:0] addr_arr;
   logic [MASTERS-1:0][DW-1:0] wdata_arr;
   logic [MASTERS-1:0]         elig;
   logic                       found;
   logic [GW-1:0]              gsel;
   logic [GW-1:0]              idx;
   logic                       timeout_hit;

   assign addr_arr  = m_addr_i;
   assign wdata_arr = m_wdata_i;

   // A requester that was just acked/errored still has req high for a cycle;
   // masking it here prevents it from being granted a second time.
   assign elig = m_req_i & ~m_ack_q & ~m_err_q;

   assign timeout_hit = (TIMEOUT != 0) && (timer_q == T_LAST);

   // Round-robin search: first eligible index at or after rr_q, wrapping.
   always_comb begin
      found = 1'b0;
      gsel  = '0;
      idx   = '0;
      for (int k = 0; k < MASTERS; k++) begin
         idx = rr_q + GW'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            gsel  = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      g_d       = g_q;
      timer_d   = timer_q;
      m_ack_d   = '0;
      m_resp_d  = '0;
      m_err_d   = '0;
      m_rdata_d = m_rdata_q;
      s_req_d   = 1'b0;
      s_cmd_d   = s_cmd_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               g_d      = gsel;
               s_req_d  = 1'b1;
               s_cmd_d  = m_cmd_i[gsel];
               s_addr_d = addr_arr[gsel];
               if (m_cmd_i[gsel]) s_wdata_d = wdata_arr[gsel];
               timer_d  = '0;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // s_ack wins over a simultaneous s_resp and over the timeout.
            if (s_ack_i) begin
               m_ack_d[g_q] = 1'b1;
               if (s_cmd_q) begin
                  state_d = IDLE;
                  rr_d    = GW'(g_q + 1'b1);
               end else begin
                  state_d = WAIT_RESP;
                  timer_d = '0;
               end
            end else if (timeout_hit) begin
               m_err_d[g_q] = 1'b1;
               state_d      = IDLE;
               rr_d         = GW'(g_q + 1'b1);
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_RESP: begin
            if (s_resp_i) begin
               m_resp_d[g_q] = 1'b1;
               m_rdata_d     = s_rdata_i;
               state_d       = IDLE;
               rr_d          = GW'(g_q + 1'b1);
            end else if (timeout_hit) begin
               m_err_d[g_q] = 1'b1;
               state_d      = IDLE;
               rr_d         = GW'(g_q + 1'b1);
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         g_q       <= '0;
         timer_q   <= '0;
         m_ack_q   <= '0;
         m_resp_q  <= '0;
         m_err_q   <= '0;
         m_rdata_q <= '0;
         s_req_q   <= 1'b0;
         s_cmd_q   <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         g_q       <= g_d;
         timer_q   <= timer_d;
         m_ack_q   <= m_ack_d;
         m_resp_q  <= m_resp_d;
         m_err_q   <= m_err_d;
         m_rdata_q <= m_rdata_d;
         s_req_q   <= s_req_d;
         s_cmd_q   <= s_cmd_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
      end
   end

   assign m_ack_o   = m_ack_q;
   assign m_resp_o  = m_resp_q;
   assign m_err_o   = m_err_q;
   assign m_rdata_o = m_rdata_q;
   assign s_req_o   = s_req_q;
   assign s_cmd_o   = s_cmd_q;
   assign s_addr_o  = s_addr_q;
   assign s_wdata_o = s_wdata_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_slave_port_arbiter
//   Directed bench for slave_port_arbiter (4 requesters, 32-bit, TIMEOUT=8).
//   Inputs change 1 time unit after the rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_slave_port_arbiter;

   localparam int M  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [M-1:0]      m_req, m_cmd;
   logic [M-1:0][AW-1:0] m_addr;
   logic [M-1:0][DW-1:0] m_wdata;
   logic [M-1:0]      m_ack, m_resp, m_err;
   logic [DW-1:0]     m_rdata;
   logic              s_req, s_cmd;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic              s_ack, s_resp;
   logic [DW-1:0]     s_rdata;

   int n_run  = 0;
   int n_fail = 0;

   slave_port_arbiter #(.MASTERS(M), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .m_req_i(m_req), .m_cmd_i(m_cmd), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
      .m_ack_o(m_ack), .m_resp_o(m_resp), .m_err_o(m_err), .m_rdata_o(m_rdata),
      .s_req_o(s_req), .s_cmd_o(s_cmd), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
      .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] gaddr [5];
   int          ack_cnt [4];
   int          ng;

   initial begin
      rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
      s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
      tick(); tick();
      rst = 1'b0;

      // ---------------- reset state
      chk("rst_outs", {m_ack, m_resp, m_err, 3'b0, s_req, 3'b0, s_cmd}, 64'h0);
      chk("rst_addr", s_addr, 64'h0);
      chk("rst_rdata", m_rdata, 64'h0);

      // ---------------- 1: write from requester 2, ack 3 cycles after s_req
      m_req = 4'b0100; m_cmd = 4'b0100;
      m_addr[2] = 32'hA000_0002; m_wdata[2] = 32'h1234_5678;
      tick();
      chk("t1_sreq", s_req, 1);
      chk("t1_scmd", s_cmd, 1);
      chk("t1_saddr", s_addr, 32'hA000_0002);
      chk("t1_swdata", s_wdata, 32'h1234_5678);
      tick();
      chk("t1_sreq_1cyc", s_req, 0);
      tick();
      chk("t1_sreq_low", s_req, 0);
      chk("t1_noack_early", m_ack, 0);
      tick();
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      chk("t1_ack", m_ack, 4'b0100);
      m_req = '0;
      tick();
      chk("t1_ack_once", m_ack, 0);

      // ---------------- 2: read from requester 1, ack then resp
      m_req = 4'b0010; m_cmd = 4'b0000; m_addr[1] = 32'hB000_0001;
      tick();
      chk("t2_sreq", s_req, 1);
      chk("t2_scmd", s_cmd, 0);
      chk("t2_saddr", s_addr, 32'hB000_0001);
      chk("t2_swdata_hold", s_wdata, 32'h1234_5678);
      s_ack = 1'b1;
      tick();
      chk("t2_ack", m_ack, 4'b0010);
      s_ack = 1'b0; m_req = '0;
      tick();
      chk("t2_noresp_yet", m_resp, 0);
      s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
      tick();
      chk("t2_resp", m_resp, 4'b0010);
      chk("t2_rdata", m_rdata, 32'hDEADBEEF);
      s_resp = 1'b0; s_rdata = '0;
      tick();
      chk("t2_resp_pulse", m_resp, 0);
      chk("t2_rdata_hold", m_rdata, 32'hDEADBEEF);

      // ---------------- 3: all four write, slave acks immediately
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_addr[i] = 32'h1000 + i;
         ack_cnt[i] = 0;
      end
      for (int i = 0; i < 5; i++) gaddr[i] = 32'hFFFF_FFFF;
      m_cmd = 4'hF; m_req = 4'hF; ng = 0;
      for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
         tick();
         for (int i = 0; i < 4; i++) if (m_ack[i]) ack_cnt[i]++;
         m_req = 4'hF & ~m_ack;
         s_ack = s_req;
         if (s_req) begin
            gaddr[ng] = s_addr;
            ng++;
         end
      end
      m_req = '0;
      tick();
      for (int i = 0; i < 4; i++) if (m_ack[i]) ack_cnt[i]++;
      s_ack = 1'b0;
      chk("t3_g0", gaddr[0], 32'h1000);
      chk("t3_g1", gaddr[1], 32'h1001);
      chk("t3_g2", gaddr[2], 32'h1002);
      chk("t3_g3", gaddr[3], 32'h1003);
      chk("t3_g4", gaddr[4], 32'h1000);
      chk("t3_acks", {ack_cnt[0][7:0], ack_cnt[1][7:0], ack_cnt[2][7:0], ack_cnt[3][7:0]},
          32'h02010101);

      // ---------------- 4: watchdog, slave never acks (rr now at 1)
      m_req = 4'b1000; m_cmd = 4'b1000; m_addr[3] = 32'hC000_0003;
      tick();
      chk("t4_sreq", s_req, 1);
      chk("t4_saddr", s_addr, 32'hC000_0003);
      for (int i = 0; i < 7; i++) tick();
      chk("t4_noerr_early", m_err, 0);
      tick();
      chk("t4_err", m_err, 4'b1000);
      s_ack = 1'b1; m_req = '0;
      tick();
      chk("t4_late_ack", m_ack, 0);
      chk("t4_err_pulse", m_err, 0);
      s_ack = 1'b0;
      m_req = 4'b0001; m_cmd = 4'b0001; m_addr[0] = 32'hD000_0000;
      tick();
      chk("t4_next_sreq", s_req, 1);
      chk("t4_next_saddr", s_addr, 32'hD000_0000);
      s_ack = 1'b1;
      tick();
      chk("t4_next_ack", m_ack, 4'b0001);
      s_ack = 1'b0; m_req = '0;

      // ---------------- 5: reset while waiting for the read response
      m_req = 4'b0010; m_cmd = 4'b0000;
      tick();
      chk("t5_sreq", s_req, 1);
      s_ack = 1'b1;
      tick();
      chk("t5_ack", m_ack, 4'b0010);
      s_ack = 1'b0; m_req = '0;
      rst = 1'b1;
      tick();
      chk("t5_rst_outs", {m_ack, m_resp, m_err, 3'b0, s_req, 3'b0, s_cmd}, 64'h0);
      chk("t5_rst_data", {s_addr, s_wdata}, 64'h0);
      chk("t5_rst_rdata", m_rdata, 64'h0);
      rst = 1'b0; s_resp = 1'b1; s_rdata = 32'hCAFE_F00D;
      tick();
      s_resp = 1'b0;
      chk("t5_no_resp", m_resp, 0);
      chk("t5_rdata_zero", m_rdata, 64'h0);

      // ---------------- 6: back-to-back writes from requester 0
      m_cmd = 4'b0001; m_addr[0] = 32'hE000_0000;
      for (int n = 0; n < 2; n++) begin
         m_req = 4'b0001; m_wdata[0] = 32'h5555_0000 + n;
         tick();
         chk("t6_sreq", s_req, 1);
         chk("t6_swdata", s_wdata, 32'h5555_0000 + n);
         s_ack = 1'b1;
         tick();
         s_ack = 1'b0;
         chk("t6_ack", m_ack, 4'b0001);
         // requester still holds req during the ack cycle
         tick();
         chk("t6_no_dup", {m_ack, 3'b0, s_req}, 0);
         m_req = '0;
         tick();
         chk("t6_idle", s_req, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
